// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative data cache array. True-LRU replacement
// with invalid-first victim choice, sequenced multi-beat line refill,
// handshaked dirty-line write-back and a whole-cache invalidate sweep.
// Ports:
//   clk, rst (async, active-low)
//   addr/load/edit/u_b_h_w/din   : core lookup, read and byte/half/word write
//   fill_start/fill_valid/fill_data : refill of addr's set into the victim way
//   wb_start/wb_ready            : write-back of the victim line for addr
//   inval_all                    : invalidate sweep over all sets
//   hit/dout                     : registered lookup result and extended read data
//   victim_valid/dirty/tag/way   : registered victim information for addr's set
//   busy                         : a fill, write-back or sweep is in progress
//   wb_valid/wb_data/wb_last     : write-back word stream
//   fill_done                    : one-cycle pulse once a refilled line is installed
module cache_nway #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 32,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned IDX_W     = $clog2(SETS),
  localparam int unsigned WRD_W     = $clog2(LINE_WORDS),
  localparam int unsigned WAY_W     = $clog2(WAYS),
  localparam int unsigned TAG_BITS  = ADDR_BITS - IDX_W - WRD_W - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 load,
  input  logic                 edit,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          din,
  input  logic                 fill_start,
  input  logic                 fill_valid,
  input  logic [31:0]          fill_data,
  input  logic                 wb_start,
  input  logic                 wb_ready,
  input  logic                 inval_all,
  output logic                 hit,
  output logic [31:0]          dout,
  output logic                 victim_valid,
  output logic                 victim_dirty,
  output logic [TAG_BITS-1:0]  victim_tag,
  output logic [WAY_W-1:0]     victim_way,
  output logic                 busy,
  output logic                 wb_valid,
  output logic [31:0]          wb_data,
  output logic                 wb_last,
  output logic                 fill_done
);

  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);
  localparam logic [WAY_W-1:0] OLDEST    = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WB = 2'd2, SWEEP = 2'd3} state_t;
  state_t state, state_nx;

  // Address fields: tag | index | word | byte(2)
  logic [TAG_BITS-1:0] a_tag;
  logic [IDX_W-1:0]    a_idx;
  logic [WRD_W-1:0]    a_wrd;
  logic [1:0]          a_off;
  assign a_tag = addr[ADDR_BITS-1 -: TAG_BITS];
  assign a_idx = addr[2+WRD_W +: IDX_W];
  assign a_wrd = addr[2 +: WRD_W];
  assign a_off = addr[1:0];

  // Storage: tag/data arrays carry no reset, valid/dirty/age do
  logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
  logic [31:0]         data_mem [SETS][WAYS][LINE_WORDS];
  logic [WAYS-1:0]     valid_q  [SETS];
  logic [WAYS-1:0]     dirty_q  [SETS];
  logic [WAY_W-1:0]    age_q    [SETS][WAYS];

  // Transaction context
  logic [IDX_W-1:0]    fill_idx, wb_idx, sweep_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic [WAY_W-1:0]    fill_way, wb_way;
  logic [WRD_W-1:0]    fill_k, wb_k, wb_nk;
  assign wb_nk = WRD_W'(wb_k + 1'b1);

  // Tag compare across the addressed set
  logic             lookup_hit;
  logic [WAY_W-1:0] hit_way;
  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (valid_q[a_idx][i] && tag_mem[a_idx][i] == a_tag) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(i);
      end
    end
  end

  // Victim: lowest-indexed invalid way, else the oldest way
  logic [WAY_W-1:0] vic_way, vic_inv, vic_lru;
  logic             any_inv;
  always_comb begin
    vic_inv = '0;
    vic_lru = '0;
    any_inv = 1'b0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!valid_q[a_idx][i]) begin
        vic_inv = WAY_W'(i);
        any_inv = 1'b1;
      end
    end
    for (int i = 0; i < int'(WAYS); i++) begin
      if (age_q[a_idx][i] == OLDEST) vic_lru = WAY_W'(i);
    end
    vic_way = any_inv ? vic_inv : vic_lru;
  end

  // Load extraction/extension and store merge on the hitting word
  logic [31:0] rd_word, ld_data, merged, wr_rep;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [3:0]  wr_be;
  always_comb begin
    rd_word = data_mem[a_idx][hit_way][a_wrd];
    rd_byte = 8'(rd_word >> {a_off, 3'b000});
    rd_half = 16'(rd_word >> {a_off[1], 4'b0000});
    case (u_b_h_w[1:0])
      2'b00:   ld_data = u_b_h_w[2] ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ld_data = u_b_h_w[2] ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase
    // Replicate store data so any enabled lane already sees its bytes
    case (u_b_h_w[1:0])
      2'b00: begin
        wr_be  = 4'b0001 << a_off;
        wr_rep = {4{din[7:0]}};
      end
      2'b01: begin
        wr_be  = 4'b0011 << {a_off[1], 1'b0};
        wr_rep = {2{din[15:0]}};
      end
      default: begin
        wr_be  = 4'b1111;
        wr_rep = din;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = wr_be[b] ? wr_rep[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  // Next-state and per-cycle command decode
  logic do_sweep_start, do_fill_start, do_wb_start, do_edit, do_load;
  logic fill_beat, fill_last, wb_xfer, wb_done;
  always_comb begin
    state_nx       = state;
    do_sweep_start = 1'b0;
    do_fill_start  = 1'b0;
    do_wb_start    = 1'b0;
    do_edit        = 1'b0;
    do_load        = 1'b0;
    fill_beat      = 1'b0;
    fill_last      = 1'b0;
    wb_xfer        = 1'b0;
    wb_done        = 1'b0;
    case (state)
      IDLE: begin
        if (inval_all) begin
          do_sweep_start = 1'b1;
          state_nx       = SWEEP;
        end else if (fill_start) begin
          do_fill_start = 1'b1;
          state_nx      = FILL;
        end else if (wb_start) begin
          do_wb_start = 1'b1;
          state_nx    = WB;
        end else if (edit) begin
          do_edit = 1'b1;
        end else if (load) begin
          do_load = 1'b1;
        end
      end
      FILL: begin
        if (fill_valid) begin
          fill_beat = 1'b1;
          if (fill_k == LAST_WORD) begin
            fill_last = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      WB: begin
        // An invalid victim never raises wb_valid and leaves after one cycle
        if (!wb_valid) begin
          state_nx = IDLE;
        end else if (wb_ready) begin
          wb_xfer = 1'b1;
          if (wb_k == LAST_WORD) begin
            wb_done  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      SWEEP: begin
        if (sweep_idx == LAST_SET) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // LRU refresh target: completed fill, or a load/edit hit
  logic             touch_en;
  logic [IDX_W-1:0] t_set;
  logic [WAY_W-1:0] t_way;
  assign touch_en = fill_last | ((do_edit | do_load) & lookup_hit);
  assign t_set    = fill_last ? fill_idx : a_idx;
  assign t_way    = fill_last ? fill_way : hit_way;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Valid, dirty and LRU ages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (state == SWEEP) begin
        valid_q[sweep_idx] <= '0;
        dirty_q[sweep_idx] <= '0;
        for (int w = 0; w < int'(WAYS); w++) age_q[sweep_idx][w] <= WAY_W'(w);
      end
      // A line under refill must never hit
      if (do_fill_start) begin
        valid_q[a_idx][vic_way] <= 1'b0;
        dirty_q[a_idx][vic_way] <= 1'b0;
      end
      if (fill_last) begin
        valid_q[fill_idx][fill_way] <= 1'b1;
        dirty_q[fill_idx][fill_way] <= 1'b0;
      end
      if (do_edit && lookup_hit) dirty_q[a_idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[wb_idx][wb_way] <= 1'b0;
      if (touch_en) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          if (age_q[t_set][w] < age_q[t_set][t_way]) age_q[t_set][w] <= WAY_W'(age_q[t_set][w] + 1'b1);
        end
        age_q[t_set][t_way] <= '0;
      end
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk) begin
    if (fill_beat) data_mem[fill_idx][fill_way][fill_k] <= fill_data;
    if (fill_last) tag_mem[fill_idx][fill_way] <= fill_tag;
    if (do_edit && lookup_hit) data_mem[a_idx][hit_way][a_wrd] <= merged;
  end

  // Transaction context and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_idx     <= '0;
      fill_tag     <= '0;
      fill_way     <= '0;
      fill_k       <= '0;
      wb_idx       <= '0;
      wb_way       <= '0;
      wb_k         <= '0;
      sweep_idx    <= '0;
      hit          <= 1'b0;
      dout         <= '0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
      victim_way   <= '0;
      busy         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_last      <= 1'b0;
      fill_done    <= 1'b0;
    end else begin
      if (do_fill_start) begin
        fill_idx <= a_idx;
        fill_tag <= a_tag;
        fill_way <= vic_way;
        fill_k   <= '0;
      end else if (fill_beat) begin
        fill_k <= WRD_W'(fill_k + 1'b1);
      end

      if (do_wb_start) begin
        wb_idx   <= a_idx;
        wb_way   <= vic_way;
        wb_k     <= '0;
        wb_valid <= valid_q[a_idx][vic_way];
        wb_data  <= data_mem[a_idx][vic_way][WRD_W'(0)];
        wb_last  <= 1'b0;
      end else if (wb_done) begin
        wb_valid <= 1'b0;
        wb_last  <= 1'b0;
      end else if (wb_xfer) begin
        wb_k    <= wb_nk;
        wb_data <= data_mem[wb_idx][wb_way][wb_nk];
        wb_last <= (wb_nk == LAST_WORD);
      end

      if (do_sweep_start)      sweep_idx <= '0;
      else if (state == SWEEP) sweep_idx <= IDX_W'(sweep_idx + 1'b1);

      hit  <= (do_edit | do_load) & lookup_hit;
      dout <= (do_load && lookup_hit) ? ld_data : 32'd0;
      if (state == IDLE) begin
        victim_valid <= valid_q[a_idx][vic_way];
        victim_dirty <= dirty_q[a_idx][vic_way];
        victim_tag   <= tag_mem[a_idx][vic_way];
        victim_way   <= vic_way;
      end
      busy      <= (state_nx != IDLE);
      fill_done <= fill_last;
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: directed bench for cache_nway. A recency-list model of the
// cache is compared against the DUT on every cycle; literal expectations in
// the directed sequence pin the model.
module tb_cache_nway;
  localparam int AB = 32, WAYS = 4, SETS = 32, LW = 4;
  localparam int WRD_W = 2, TAGB = 23, WAY_W = 2;

  logic             clk = 1'b0, rst = 1'b0;
  logic [AB-1:0]    addr = '0;
  logic             load = 0, edit = 0, fill_start = 0, fill_valid = 0;
  logic             wb_start = 0, wb_ready = 0, inval_all = 0;
  logic [2:0]       u_b_h_w = 3'b010;
  logic [31:0]      din = '0, fill_data = '0;
  logic             hit, victim_valid, victim_dirty, busy, wb_valid, wb_last, fill_done;
  logic [31:0]      dout, wb_data;
  logic [TAGB-1:0]  victim_tag;
  logic [WAY_W-1:0] victim_way;

  cache_nway #(.ADDR_BITS(AB), .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .load(load), .edit(edit), .u_b_h_w(u_b_h_w),
    .din(din), .fill_start(fill_start), .fill_valid(fill_valid), .fill_data(fill_data),
    .wb_start(wb_start), .wb_ready(wb_ready), .inval_all(inval_all), .hit(hit), .dout(dout),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .victim_way(victim_way), .busy(busy), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_last(wb_last), .fill_done(fill_done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_FILL = 1, M_WB = 2, M_SWEEP = 3;
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][LW];
  int          order   [SETS][WAYS];   // recency list, index 0 = most recent
  int mode = M_IDLE, k = 0, f_idx = 0, f_way = 0, w_idx = 0, w_way = 0, s_idx = 0;
  int unsigned f_tag = 0;
  bit          e_hit = 0, e_vvalid = 0, e_vdirty = 0, e_busy = 0, e_wbv = 0, e_wbl = 0, e_fdone = 0;
  logic [31:0] e_dout = '0, e_wbd = '0;
  int unsigned e_vtag = 0;
  int          e_vway = 0;
  int          a_idx, a_wrd, a_off, v, hw;
  int unsigned a_tag;

  function automatic int victim_of(input int s);
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    return order[s][WAYS-1];
  endfunction

  function automatic int lookup(input int s, input int unsigned t);
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  task automatic touch(input int s, input int w);
    int p = 0;
    for (int j = 0; j < WAYS; j++) if (order[s][j] == w) p = j;
    for (int j = p; j > 0; j--) order[s][j] = order[s][j-1];
    order[s][0] = w;
  endtask

  task automatic clear_set(input int s);
    for (int w = 0; w < WAYS; w++) begin
      m_valid[s][w] = 0;
      m_dirty[s][w] = 0;
      order[s][w]   = w;
    end
  endtask

  function automatic logic [31:0] ext_load(input logic [31:0] word, input int off, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00: begin
        r = (word >> (8 * off)) & 32'hFF;
        if (!f3[2] && r[7]) r = r | 32'hFFFFFF00;
      end
      2'b01: begin
        r = (word >> (8 * (off & 2))) & 32'hFFFF;
        if (!f3[2] && r[15]) r = r | 32'hFFFF0000;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input int off, input logic [2:0] f3);
    logic [31:0] r = old;
    int n, st;
    n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    st = (n == 1) ? off : (n == 2) ? (off & 2) : 0;
    for (int b = 0; b < n; b++) r[8*(st+b) +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) clear_set(s);
      mode = M_IDLE;
      {e_hit, e_vvalid, e_vdirty, e_busy, e_wbv, e_wbl, e_fdone} = '0;
      e_dout = '0; e_wbd = '0; e_vtag = 0; e_vway = 0;
    end else begin
      a_idx = int'((addr >> (2 + WRD_W)) % SETS);
      a_tag = addr >> (2 + WRD_W + 5);
      a_wrd = int'((addr >> 2) % LW);
      a_off = int'(addr % 4);
      e_fdone = 0;
      e_hit   = 0;
      e_dout  = '0;
      case (mode)
        M_IDLE: begin
          v = victim_of(a_idx);
          e_vway = v; e_vvalid = m_valid[a_idx][v]; e_vdirty = m_dirty[a_idx][v]; e_vtag = m_tag[a_idx][v];
          hw = lookup(a_idx, a_tag);
          if (inval_all) begin
            mode = M_SWEEP; s_idx = 0;
          end else if (fill_start) begin
            f_idx = a_idx; f_tag = a_tag; f_way = v; k = 0;
            m_valid[a_idx][v] = 0; m_dirty[a_idx][v] = 0;
            mode = M_FILL;
          end else if (wb_start) begin
            w_idx = a_idx; w_way = v; k = 0; mode = M_WB;
            e_wbv = m_valid[a_idx][v]; e_wbl = 0;
            e_wbd = m_data[a_idx][v][0];
          end else if (edit) begin
            if (hw >= 0) begin
              e_hit = 1;
              m_data[a_idx][hw][a_wrd] = merge(m_data[a_idx][hw][a_wrd], din, a_off, u_b_h_w);
              m_dirty[a_idx][hw] = 1;
              touch(a_idx, hw);
            end
          end else if (load) begin
            if (hw >= 0) begin
              e_hit = 1;
              e_dout = ext_load(m_data[a_idx][hw][a_wrd], a_off, u_b_h_w);
              touch(a_idx, hw);
            end
          end
        end
        M_FILL: if (fill_valid) begin
          m_data[f_idx][f_way][k] = fill_data;
          if (k == LW - 1) begin
            m_valid[f_idx][f_way] = 1; m_dirty[f_idx][f_way] = 0; m_tag[f_idx][f_way] = f_tag;
            touch(f_idx, f_way);
            e_fdone = 1; mode = M_IDLE;
          end else k++;
        end
        M_WB: begin
          if (!e_wbv) mode = M_IDLE;
          else if (wb_ready) begin
            if (k == LW - 1) begin
              m_dirty[w_idx][w_way] = 0; e_wbv = 0; e_wbl = 0; mode = M_IDLE;
            end else begin
              k++;
              e_wbd = m_data[w_idx][w_way][k];
              e_wbl = (k == LW - 1);
            end
          end
        end
        default: begin
          clear_set(s_idx);
          if (s_idx == SETS - 1) mode = M_IDLE;
          else s_idx++;
        end
      endcase
      e_busy = (mode != M_IDLE);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("cmp_hit", 32'(hit), 32'(e_hit));
      chk("cmp_dout", dout, e_dout);
      chk("cmp_vvalid", 32'(victim_valid), 32'(e_vvalid));
      chk("cmp_vdirty", 32'(victim_dirty), 32'(e_vdirty));
      chk("cmp_vway", 32'(victim_way), 32'(e_vway));
      if (e_vvalid) chk("cmp_vtag", 32'(victim_tag), e_vtag);
      chk("cmp_busy", 32'(busy), 32'(e_busy));
      chk("cmp_wbv", 32'(wb_valid), 32'(e_wbv));
      if (e_wbv) chk("cmp_wbd", wb_data, e_wbd);
      chk("cmp_wbl", 32'(wb_last), 32'(e_wbl));
      chk("cmp_fdone", 32'(fill_done), 32'(e_fdone));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f);
    addr = a; u_b_h_w = f; load = 1;
    tick();
    load = 0;
  endtask

  task automatic do_fill(input logic [31:0] a, input logic [31:0] base, input bit gap);
    addr = a; fill_start = 1;
    tick();
    fill_start = 0;
    for (int b = 0; b < LW; b++) begin
      fill_valid = 1; fill_data = base * 32'(b + 1);
      tick();
      fill_valid = 0;
      if (gap && b == 1) tick();
    end
    chk("fill_done_pulse", 32'(fill_done), 32'd1);
  endtask

  initial begin
    logic [31:0] wb_exp [4];
    bit pat [5];
    int got, n, p;
    bit r, cur_v;
    wb_exp = '{32'h11111111, 32'h22222222, 32'h3333FF33, 32'h44444444};
    pat    = '{1, 0, 1, 1, 1};

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    rst = 1;
    tick();

    do_load(32'h100, 3'b010);
    chk("cold_hit", 32'(hit), 32'd0);
    chk("cold_dout", dout, 32'd0);
    chk("cold_vway", 32'(victim_way), 32'd0);
    chk("cold_vvalid", 32'(victim_valid), 32'd0);

    do_fill(32'h100, 32'h11111111, 1'b1);
    tick();
    chk("fill_done_drop", 32'(fill_done), 32'd0);
    do_load(32'h108, 3'b010);
    chk("lw108_hit", 32'(hit), 32'd1);
    chk("lw108", dout, 32'h33333333);
    do_load(32'h10E, 3'b001);
    chk("lh10e", dout, 32'h00004444);

    addr = 32'h109; u_b_h_w = 3'b000; din = 32'hFF; edit = 1;
    tick();
    edit = 0;
    do_load(32'h108, 3'b010);
    chk("lw108_edited", dout, 32'h3333FF33);
    do_load(32'h109, 3'b000);
    chk("lb109", dout, 32'hFFFFFFFF);
    do_load(32'h109, 3'b100);
    chk("lbu109", dout, 32'h000000FF);
    addr = 32'h904; din = 32'h12345678; u_b_h_w = 3'b010; edit = 1;
    tick();
    edit = 0;
    chk("edit_miss_hit", 32'(hit), 32'd0);

    do_fill(32'h300, 32'h01010101, 1'b0);
    do_fill(32'h500, 32'h02020202, 1'b0);
    do_fill(32'h700, 32'h03030303, 1'b0);
    addr = 32'h100;
    tick();
    chk("full_vdirty", 32'(victim_dirty), 32'd1);
    chk("full_vway", 32'(victim_way), 32'd0);

    do_fill(32'h200, 32'h10000001, 1'b0);
    do_fill(32'h400, 32'h20000002, 1'b0);
    do_fill(32'h600, 32'h30000003, 1'b0);
    do_fill(32'h800, 32'h40000004, 1'b0);
    do_load(32'h200, 3'b010);
    chk("lru_t1_dout", dout, 32'h10000001);
    tick();
    chk("lru_vway1", 32'(victim_way), 32'd1);
    do_load(32'h400, 3'b010);
    tick();
    chk("lru_vway2", 32'(victim_way), 32'd2);

    addr = 32'h100; wb_start = 1;
    tick();
    wb_start = 0;
    chk("wb_first_valid", 32'(wb_valid), 32'd1);
    got = 0; p = 0;
    while (got < 4 && p < 20) begin
      r = (p < 5) ? pat[p] : 1'b1;
      wb_ready = r;
      cur_v = wb_valid;
      if (cur_v) begin
        chk("wb_word", wb_data, wb_exp[got]);
        chk("wb_last", 32'(wb_last), (got == 3) ? 32'd1 : 32'd0);
      end
      tick();
      if (r && cur_v) got++;
      else if (cur_v) chk("wb_hold", wb_data, wb_exp[got]);
      p++;
    end
    wb_ready = 0;
    chk("wb_count", 32'(got), 32'd4);
    chk("wb_drop", 32'(wb_valid), 32'd0);
    tick();
    chk("wb_vdirty", 32'(victim_dirty), 32'd0);
    chk("wb_vvalid", 32'(victim_valid), 32'd1);
    do_load(32'h100, 3'b010);
    chk("wb_still_hit", 32'(hit), 32'd1);
    chk("wb_still_dout", dout, 32'h11111111);

    addr = 32'h050; wb_start = 1;
    tick();
    wb_start = 0;
    chk("wb_empty_valid", 32'(wb_valid), 32'd0);
    chk("wb_empty_busy", 32'(busy), 32'd1);
    tick();
    chk("wb_empty_done", 32'(busy), 32'd0);

    inval_all = 1;
    tick();
    inval_all = 0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("sweep_cycles", 32'(n), 32'd32);
    do_load(32'h100, 3'b010);
    chk("sweep_miss100", 32'(hit), 32'd0);
    do_load(32'h200, 3'b010);
    chk("sweep_miss200", 32'(hit), 32'd0);
    do_load(32'h700, 3'b010);
    chk("sweep_miss700", 32'(hit), 32'd0);

    do_fill(32'h100, 32'h0A0A0A0A, 1'b0);
    addr = 32'h100; fill_start = 1;
    tick();
    fill_start = 0;
    for (int b = 0; b < 2; b++) begin
      fill_valid = 1; fill_data = 32'h55555555;
      tick();
    end
    fill_valid = 0;
    #2 rst = 0;
    tick();
    tick();
    #2 rst = 1;
    tick();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    do_load(32'h100, 3'b010);
    chk("rst_mid_hit", 32'(hit), 32'd0);
    chk("rst_mid_vvalid", 32'(victim_valid), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
